// File: rtl/boundingbox_multi.sv
// boundingbox_multi
//
// Scans an IMG_W x IMG_H frame of 16-bit pixels in word-addressed memory,
// row-major from BASE_ADDR. It computes one bounding box per colour channel,
// for N_CH channels, in a single pass. Memory read data arrives RD_LAT
// cycles after its read strobe.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a scan (sampled only while idle)
//   done                  one-cycle pulse; results valid from this cycle
//   busy                  high from start acceptance through the done cycle
//   addr, rden            pixel word address and read strobe
//   rddata                pixel data, RD_LAT cycles after its rden
//   key, mask             per-channel match value / compare mask (16 bits each)
//   found                 per-channel "at least one pixel matched"
//   xMin/xMax/yMin/yMax   per-channel box, 11 bits each, channel c at [11c+10:11c]
//   count                 (only with BOUNDINGBOX_COUNT_EN) per-channel hit count,
//                         22 bits each, saturating
//
// Optional feature macro: BOUNDINGBOX_COUNT_EN
module boundingbox_multi #(
  parameter int          IMG_W     = 160,
  parameter int          IMG_H     = 120,
  parameter int          N_CH      = 2,
  parameter int          RD_LAT    = 1,
  parameter logic [23:0] BASE_ADDR = 24'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 done,
  output logic                 busy,
  output logic [23:0]          addr,
  output logic                 rden,
  input  logic [15:0]          rddata,
  input  logic [N_CH*16-1:0]   key,
  input  logic [N_CH*16-1:0]   mask,
  output logic [N_CH-1:0]      found,
  output logic [N_CH*11-1:0]   xMin,
  output logic [N_CH*11-1:0]   xMax,
  output logic [N_CH*11-1:0]   yMin,
  output logic [N_CH*11-1:0]   yMax
`ifdef BOUNDINGBOX_COUNT_EN
  ,
  output logic [N_CH*22-1:0]   count
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [10:0] X_LAST     = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST     = 11'(IMG_H - 1);
  localparam logic [2:0]  DRAIN_LAST = 3'(RD_LAT - 1);
  localparam logic [10:0] MIN_INIT   = 11'h7FF;

  function automatic logic [10:0] min11(input logic [10:0] a, input logic [10:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [10:0] max11(input logic [10:0] a, input logic [10:0] b);
    return (b > a) ? b : a;
  endfunction

`ifdef BOUNDINGBOX_COUNT_EN
  function automatic logic [21:0] sat_inc22(input logic [21:0] v);
    return (v == 22'h3FFFFF) ? v : v + 22'd1;
  endfunction
`endif

  state_t      state, state_nx;
  logic        accept, last_pix, drain_last, fin;
  logic [10:0] x_p0, y_p0;
  logic [2:0]  drain_cnt;

  // Coordinates of in-flight reads; element i is stage i+1 after issue.
  logic [10:0]       x_pn [RD_LAT];
  logic [10:0]       y_pn [RD_LAT];
  logic [RD_LAT-1:0] vld_pn;

  logic [15:0] key_q  [N_CH];
  logic [15:0] mask_q [N_CH];

  logic [10:0]     xmin_q [N_CH], xmax_q [N_CH], ymin_q [N_CH], ymax_q [N_CH];
  logic [10:0]     xmin_nx [N_CH], xmax_nx [N_CH], ymin_nx [N_CH], ymax_nx [N_CH];
  logic [N_CH-1:0] hit_q, hit_nx, match;
`ifdef BOUNDINGBOX_COUNT_EN
  logic [21:0]     cnt_q [N_CH], cnt_nx [N_CH];
`endif

  assign accept     = (state == IDLE) && start;
  assign last_pix   = (x_p0 == X_LAST) && (y_p0 == Y_LAST);
  assign drain_last = (drain_cnt == DRAIN_LAST);
  assign fin        = (state == DRAIN) && drain_last;
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (last_pix) state_nx = DRAIN;
      DRAIN:   if (drain_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: read issue. x_p0/y_p0 name the pixel being read this cycle;
  // row-major order makes the address a plain increment (wrapping at 2^24).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0      <= '0;
      y_p0      <= '0;
      addr      <= '0;
      rden      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_p0 <= '0;
          y_p0 <= '0;
          addr <= BASE_ADDR;
          rden <= 1'b1;
        end
        SCAN: if (last_pix) begin
          rden      <= 1'b0;
          drain_cnt <= '0;
        end else begin
          addr <= addr + 24'd1;
          if (x_p0 == X_LAST) begin
            x_p0 <= '0;
            y_p0 <= y_p0 + 11'd1;
          end else begin
            x_p0 <= x_p0 + 11'd1;
          end
        end
        DRAIN:   drain_cnt <= drain_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Stages p1..pRD_LAT: coordinates ride alongside the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pn <= '0;
    end else begin
      vld_pn[0] <= rden;
      for (int i = 1; i < RD_LAT; i++) vld_pn[i] <= vld_pn[i-1];
    end
  end

  always_ff @(posedge clk) begin
    x_pn[0] <= x_p0;
    y_pn[0] <= y_p0;
    for (int i = 1; i < RD_LAT; i++) begin
      x_pn[i] <= x_pn[i-1];
      y_pn[i] <= y_pn[i-1];
    end
    if (accept) begin
      for (int c = 0; c < N_CH; c++) begin
        key_q[c]  <= key[16*c +: 16];
        mask_q[c] <= mask[16*c +: 16];
      end
    end
  end

  // Final stage: match against the returning pixel and fold into the boxes.
  always_comb begin
    match  = '0;
    hit_nx = hit_q;
    for (int c = 0; c < N_CH; c++) begin
      xmin_nx[c] = xmin_q[c];
      xmax_nx[c] = xmax_q[c];
      ymin_nx[c] = ymin_q[c];
      ymax_nx[c] = ymax_q[c];
`ifdef BOUNDINGBOX_COUNT_EN
      cnt_nx[c]  = cnt_q[c];
`endif
      match[c] = vld_pn[RD_LAT-1] &&
                 ((rddata & mask_q[c]) == (key_q[c] & mask_q[c]));
      if (accept) begin
        xmin_nx[c] = MIN_INIT;
        xmax_nx[c] = '0;
        ymin_nx[c] = MIN_INIT;
        ymax_nx[c] = '0;
        hit_nx[c]  = 1'b0;
`ifdef BOUNDINGBOX_COUNT_EN
        cnt_nx[c]  = '0;
`endif
      end else if (match[c]) begin
        xmin_nx[c] = min11(xmin_q[c], x_pn[RD_LAT-1]);
        xmax_nx[c] = max11(xmax_q[c], x_pn[RD_LAT-1]);
        ymin_nx[c] = min11(ymin_q[c], y_pn[RD_LAT-1]);
        ymax_nx[c] = max11(ymax_q[c], y_pn[RD_LAT-1]);
        hit_nx[c]  = 1'b1;
`ifdef BOUNDINGBOX_COUNT_EN
        cnt_nx[c]  = sat_inc22(cnt_q[c]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    hit_q <= hit_nx;
    for (int c = 0; c < N_CH; c++) begin
      xmin_q[c] <= xmin_nx[c];
      xmax_q[c] <= xmax_nx[c];
      ymin_q[c] <= ymin_nx[c];
      ymax_q[c] <= ymax_nx[c];
`ifdef BOUNDINGBOX_COUNT_EN
      cnt_q[c]  <= cnt_nx[c];
`endif
    end
  end

  // Result registers load on the edge entering DONE from the next-state
  // accumulators, so the last pixel (consumed on that same edge) is included
  // and the results are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found <= '0;
      xMin  <= '0;
      xMax  <= '0;
      yMin  <= '0;
      yMax  <= '0;
`ifdef BOUNDINGBOX_COUNT_EN
      count <= '0;
`endif
    end else if (fin) begin
      found <= hit_nx;
      for (int c = 0; c < N_CH; c++) begin
        xMin[11*c +: 11]  <= xmin_nx[c];
        xMax[11*c +: 11]  <= xmax_nx[c];
        yMin[11*c +: 11]  <= ymin_nx[c];
        yMax[11*c +: 11]  <= ymax_nx[c];
`ifdef BOUNDINGBOX_COUNT_EN
        count[22*c +: 22] <= cnt_nx[c];
`endif
      end
    end
  end

endmodule

// File: tb/tb_boundingbox_multi.sv
// Bench for boundingbox_multi: three instances (RD_LAT 2, 1, 4) on an 8x4
// frame at base 0x100 share one frame memory, each with its own read-latency
// pipe. Results are compared with a pixel-by-pixel reference box computation.
module tb_boundingbox_multi;

  localparam int          W    = 8;
  localparam int          H    = 4;
  localparam int          NPIX = W * H;
  localparam logic [23:0] BASE = 24'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_bc;
  logic [31:0] key, mask;
  logic        done [3], busy [3], rden [3];
  logic [23:0] addr [3];
  logic [15:0] rddata [3];
  logic [1:0]  found [3];
  logic [21:0] xmn [3], xmx [3], ymn [3], ymx [3];
`ifdef BOUNDINGBOX_COUNT_EN
  logic [43:0] cnt [3];
`endif

  logic [15:0] frame [NPIX];
  logic [15:0] pipe [3][4];

  int checks = 0;
  int errors = 0;
  int exp_f [2], exp_xmn [2], exp_xmx [2], exp_ymn [2], exp_ymx [2], exp_n [2];

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int LAT = (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    boundingbox_multi #(
      .IMG_W(W), .IMG_H(H), .N_CH(2), .RD_LAT(LAT), .BASE_ADDR(BASE)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(d == 0 ? start_a : start_bc),
      .done(done[d]), .busy(busy[d]), .addr(addr[d]), .rden(rden[d]),
      .rddata(rddata[d]), .key(key), .mask(mask), .found(found[d]),
      .xMin(xmn[d]), .xMax(xmx[d]), .yMin(ymn[d]), .yMax(ymx[d])
`ifdef BOUNDINGBOX_COUNT_EN
      , .count(cnt[d])
`endif
    );
    assign rddata[d] = pipe[d][LAT-1];
  end

  // Memory: data for a read appears LAT cycles later; idle slots carry junk.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      pipe[d][0] <= rden[d] ? frame[5'(addr[d] - BASE)] : 16'($urandom);
      for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk every pixel, test the masked compare, widen the box.
  task automatic model(input logic [15:0] k0, input logic [15:0] m0,
                       input logic [15:0] k1, input logic [15:0] m1);
    logic [15:0] k [2];
    logic [15:0] m [2];
    k[0] = k0; k[1] = k1; m[0] = m0; m[1] = m1;
    for (int c = 0; c < 2; c++) begin
      exp_f[c] = 0; exp_n[c] = 0;
      exp_xmn[c] = 2047; exp_xmx[c] = 0; exp_ymn[c] = 2047; exp_ymx[c] = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if ((frame[y*W + x] & m[c]) == (k[c] & m[c])) begin
            exp_f[c] = 1;
            exp_n[c]++;
            if (x < exp_xmn[c]) exp_xmn[c] = x;
            if (x > exp_xmx[c]) exp_xmx[c] = x;
            if (y < exp_ymn[c]) exp_ymn[c] = y;
            if (y > exp_ymx[c]) exp_ymx[c] = y;
          end
    end
  endtask

  // Random background; optionally free of red (ch0 key F800/F800) and 07E0.
  task automatic fill(input bit clean);
    logic [15:0] p;
    for (int i = 0; i < NPIX; i++) begin
      p = 16'($urandom);
      if (clean) begin
        if ((p & 16'hF800) == 16'hF800) p[15] = 1'b0;
        if (p == 16'h07E0) p[0] = 1'b1;
      end
      frame[i] = p;
    end
  endtask

  task automatic check_outs(input string tag);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("%s.d%0d.c%0d.found", tag, d, c), 64'(found[d][c]), 64'(exp_f[c]));
        chk($sformatf("%s.d%0d.c%0d.xmin", tag, d, c), 64'(xmn[d][11*c +: 11]), 64'(exp_xmn[c]));
        chk($sformatf("%s.d%0d.c%0d.xmax", tag, d, c), 64'(xmx[d][11*c +: 11]), 64'(exp_xmx[c]));
        chk($sformatf("%s.d%0d.c%0d.ymin", tag, d, c), 64'(ymn[d][11*c +: 11]), 64'(exp_ymn[c]));
        chk($sformatf("%s.d%0d.c%0d.ymax", tag, d, c), 64'(ymx[d][11*c +: 11]), 64'(exp_ymx[c]));
`ifdef BOUNDINGBOX_COUNT_EN
        chk($sformatf("%s.d%0d.c%0d.count", tag, d, c), 64'(cnt[d][22*c +: 22]), 64'(exp_n[c]));
`endif
      end
  endtask

  // One full scan on all instances; dut 0 additionally gets start pokes in
  // mid-SCAN (cycle 10) and in its DONE cycle (cycle 35), both to be ignored.
  task automatic do_scan(input string tag, input logic [15:0] k0, input logic [15:0] m0,
                         input logic [15:0] k1, input logic [15:0] m1);
    int rd, first, last, addr_bad, busy_cnt, busy_last;
    int done_cnt [3];
    int done_at [3];
    logic [1:0]  snap_f;
    logic [21:0] snap_x;
    rd = 0; first = -1; last = -1; addr_bad = 0; busy_cnt = 0; busy_last = -1;
    snap_f = '0; snap_x = '0;
    for (int d = 0; d < 3; d++) begin done_cnt[d] = 0; done_at[d] = -1; end
    model(k0, m0, k1, m1);
    @(negedge clk);
    key = {k1, k0}; mask = {m1, m0}; start_a = 1'b1; start_bc = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0; start_bc = 1'b0; key = $urandom; mask = $urandom;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (rden[0]) begin
        if (addr[0] !== BASE + 24'(rd)) addr_bad++;
        if (first < 0) first = n;
        last = n;
        rd++;
      end
      if (busy[0]) begin busy_cnt++; busy_last = n; end
      for (int d = 0; d < 3; d++)
        if (done[d]) begin done_cnt[d]++; done_at[d] = n; end
      if (done[0]) begin snap_f = found[0]; snap_x = xmn[0]; end
      start_a = (n == 10 || n == 35);
    end
    start_a = 1'b0;
    chk({tag, ".rden_count"}, 64'(rd), 64'd32);
    chk({tag, ".first_rden"}, 64'(first), 64'd1);
    chk({tag, ".last_rden"}, 64'(last), 64'd32);
    chk({tag, ".addr_order"}, 64'(addr_bad), 64'd0);
    chk({tag, ".addr_hold"}, 64'(addr[0]), 64'(BASE + 24'd31));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd35);
    chk({tag, ".busy_last"}, 64'(busy_last), 64'd35);
    chk({tag, ".done_count_l2"}, 64'(done_cnt[0]), 64'd1);
    chk({tag, ".done_count_l1"}, 64'(done_cnt[1]), 64'd1);
    chk({tag, ".done_count_l4"}, 64'(done_cnt[2]), 64'd1);
    chk({tag, ".done_at_l2"}, 64'(done_at[0]), 64'd35);
    chk({tag, ".done_at_l1"}, 64'(done_at[1]), 64'd34);
    chk({tag, ".done_at_l4"}, 64'(done_at[2]), 64'd37);
    chk({tag, ".at_done"}, 64'({snap_f, snap_x}),
        64'({exp_f[1] != 0, exp_f[0] != 0, 11'(exp_xmn[1]), 11'(exp_xmn[0])}));
    check_outs(tag);
  endtask

  initial begin
    logic [15:0] mtab [4];
    int wait_n, dn;
    mtab[0] = 16'hC000; mtab[1] = 16'hF800; mtab[2] = 16'h0000; mtab[3] = 16'h0303;
    rst_n = 1'b0; start_a = 1'b0; start_bc = 1'b0; key = '0; mask = '0;
    fill(1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset.d%0d.ctl", d), 64'({done[d], busy[d], rden[d], found[d]}), 64'd0);
      chk($sformatf("reset.d%0d.addr", d), 64'(addr[d]), 64'd0);
      chk($sformatf("reset.d%0d.box", d), 64'({xmn[d], xmx[d]} | 44'(ymn[d]) | 44'(ymx[d])), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three red pixels on channel 0, nothing for channel 1.
    fill(1'b1);
    frame[1*W + 2] = 16'hF800;
    frame[3*W + 5] = 16'hFFFF;
    frame[0*W + 3] = 16'hF81F;
    do_scan("s1", 16'hF800, 16'hF800, 16'h07E0, 16'hFFFF);
    chk("s1.c0.found", 64'(found[0][0]), 64'd1);
    chk("s1.c0.box", 64'({xmn[0][10:0], xmx[0][10:0], ymn[0][10:0], ymx[0][10:0]}),
        64'({11'd2, 11'd5, 11'd0, 11'd3}));
    chk("s1.c1.found", 64'(found[0][1]), 64'd0);
    chk("s1.c1.box", 64'({xmn[0][21:11], xmx[0][21:11], ymn[0][21:11], ymx[0][21:11]}),
        64'({11'h7FF, 11'd0, 11'h7FF, 11'd0}));
`ifdef BOUNDINGBOX_COUNT_EN
    chk("s1.c0.count3", 64'(cnt[0][21:0]), 64'd3);
`endif

    // Only the last pixel is red; channel 1 gets a new key.
    fill(1'b1);
    frame[3*W + 7] = 16'hF800;
    do_scan("s2", 16'hF800, 16'hF800, 16'h001F, 16'h001F);
    chk("s2.l1.box", 64'({xmn[1][10:0], xmx[1][10:0], ymn[1][10:0], ymx[1][10:0]}),
        64'({11'd7, 11'd7, 11'd3, 11'd3}));
    chk("s2.l4.box", 64'({xmn[2][10:0], xmx[2][10:0], ymn[2][10:0], ymx[2][10:0]}),
        64'({11'd7, 11'd7, 11'd3, 11'd3}));

    // Random frames and keys, including a zero mask (matches everything).
    for (int i = 0; i < 4; i++) begin
      fill(1'b0);
      do_scan($sformatf("r%0d", i), frame[$urandom_range(0, NPIX-1)], mtab[i],
              16'($urandom), mtab[(i+1) % 4]);
    end

    // Reset in the middle of a scan.
    fill(1'b0);
    @(negedge clk);
    key = $urandom; mask = 32'hC000C000; start_a = 1'b1; start_bc = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0; start_bc = 1'b0;
    wait_n = 0;
    while (addr[0] !== 24'h110 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    chk("mid.reached_0x110", 64'(addr[0]), 64'h110);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid.d%0d.ctl", d), 64'({done[d], busy[d], rden[d], found[d]}), 64'd0);
      chk($sformatf("mid.d%0d.addr", d), 64'(addr[d]), 64'd0);
      chk($sformatf("mid.d%0d.box", d), 64'({xmn[d], xmx[d]} | 44'(ymn[d]) | 44'(ymx[d])), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done[0] || done[1] || done[2] || busy[0]) dn++;
    end
    chk("mid.no_done_after_abort", 64'(dn), 64'd0);
    fill(1'b0);
    do_scan("post", frame[5], 16'hF000, frame[30], 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
